// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and the single-ported memory bus of mem_arbiter.
// slave is the arbiter's view; master is the environment (core + memory) view.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 20
);
   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_ready;
   logic [31:0]       i_rdata;
   logic              i_err;

   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_ready;
   logic [31:0]       d_rdata;
   logic              d_err;

   logic              m_valid;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_wdata;
   logic              m_ready;
   logic              m_rvalid;
   logic [31:0]       m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
      output i_ready, i_rdata, i_err, d_ready, d_rdata, d_err, m_valid, m_we, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
      input  i_ready, i_rdata, i_err, d_ready, d_rdata, d_err, m_valid, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises the core's fetch and data ports onto one word-addressed memory bus,
// with address checking, one outstanding transaction and a response timeout.
module mem_arbiter #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned ADDR_W    = 20,
   parameter int unsigned TIMEOUT   = 255
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int unsigned      CNT_W     = 8;
   localparam logic [32:0]      WIN_BYTES = 33'(33'd4 << ADDR_W);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;

   state_e             state_q;
   logic               last_data_q;
   logic               gnt_data_q;
   logic               gnt_we_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               i_ready_q;
   logic               i_err_q;
   logic [31:0]        i_rdata_q;
   logic               d_ready_q;
   logic               d_err_q;
   logic [31:0]        d_rdata_q;
   logic               m_valid_q;
   logic               m_we_q;
   logic [ADDR_W-1:0]  m_addr_q;
   logic [31:0]        m_wdata_q;

   logic               grant_data_c;
   logic [31:0]        sel_addr_c;
   logic [31:0]        off_c;
   logic               bad_c;
   logic               tmo_c;

   // Round-robin tie-break only when both ports ask; address decode of the winner.
   always_comb begin
      grant_data_c = bus.d_req & (~bus.i_req | ~last_data_q);
      sel_addr_c   = grant_data_c ? bus.d_addr : bus.i_addr;
      off_c        = sel_addr_c - BASE_ADDR;
      bad_c        = (sel_addr_c[1:0] != 2'b00) || ({1'b0, off_c} >= WIN_BYTES);
      tmo_c        = (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_data_q <= 1'b0;
         gnt_data_q  <= 1'b0;
         gnt_we_q    <= 1'b0;
         cnt_q       <= '0;
         i_ready_q   <= 1'b0;
         i_err_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_ready_q   <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         m_valid_q   <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
      end else begin
         i_ready_q <= 1'b0;
         i_err_q   <= 1'b0;
         d_ready_q <= 1'b0;
         d_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (bus.i_req || bus.d_req) begin
                  last_data_q <= grant_data_c;
                  gnt_data_q  <= grant_data_c;
                  gnt_we_q    <= grant_data_c & bus.d_we;
                  if (bad_c) begin
                     // Rejected without touching the memory bus.
                     state_q <= RESP;
                     if (grant_data_c) begin
                        d_ready_q <= 1'b1;
                        d_err_q   <= 1'b1;
                        d_rdata_q <= '0;
                     end else begin
                        i_ready_q <= 1'b1;
                        i_err_q   <= 1'b1;
                        i_rdata_q <= '0;
                     end
                  end else begin
                     state_q   <= ISSUE;
                     m_valid_q <= 1'b1;
                     m_we_q    <= grant_data_c & bus.d_we;
                     m_addr_q  <= off_c[ADDR_W+1:2];
                     m_wdata_q <= bus.d_wdata;
                  end
               end
            end

            ISSUE, WAIT_RD: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (state_q == ISSUE && bus.m_ready) begin
                  m_valid_q <= 1'b0;
                  cnt_q     <= '0;
                  if (gnt_we_q) begin
                     state_q   <= RESP;
                     d_ready_q <= 1'b1;
                  end else begin
                     state_q <= WAIT_RD;
                  end
               end else if (state_q == WAIT_RD && bus.m_rvalid) begin
                  state_q <= RESP;
                  cnt_q   <= '0;
                  if (gnt_data_q) begin
                     d_ready_q <= 1'b1;
                     d_rdata_q <= bus.m_rdata;
                  end else begin
                     i_ready_q <= 1'b1;
                     i_rdata_q <= bus.m_rdata;
                  end
               end else if (tmo_c) begin
                  // Memory never answered: abandon the command and report an error.
                  state_q   <= RESP;
                  m_valid_q <= 1'b0;
                  cnt_q     <= '0;
                  if (gnt_data_q) begin
                     d_ready_q <= 1'b1;
                     d_err_q   <= 1'b1;
                     d_rdata_q <= '0;
                  end else begin
                     i_ready_q <= 1'b1;
                     i_err_q   <= 1'b1;
                     i_rdata_q <= '0;
                  end
               end
            end

            RESP: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.i_ready = i_ready_q;
   assign bus.i_err   = i_err_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_ready = d_ready_q;
   assign bus.d_err   = d_err_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a transaction-level model predicts grant order,
// completion cycle, error/data and the memory command for every request.
module tb_mem_arbiter;
   localparam logic [31:0]     BASE = 32'h8000_0000;
   localparam int unsigned     AW   = 20;
   localparam int              TO   = 16;
   localparam longint unsigned WIN  = 64'd4 << AW;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [15:0] a;     // cycles m_ready stays low before accept
      logic [15:0] r;     // cycles from accept to m_rvalid
      logic [31:0] rd;
   } req_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW)) bus ();

   mem_arbiter #(.BASE_ADDR(BASE), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   req_t iq[$];
   req_t dq[$];
   req_t i_cur, d_cur, cur;
   bit   i_act, d_act, i_done, d_done;

   // Transaction-level model state
   bit          busy, last_d, g_d, g_bad, g_we;
   int          g_cyc, acc_cyc, cmd_end, t_ready, rv_cyc;
   logic        e_err;
   logic [31:0] e_rd, rv_data, g_wdata;
   logic [AW-1:0] g_maddr;
   logic [31:0] i_rd_m, d_rd_m;
   bit          d_rd_known;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h @cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [127:0] all_outs();
      return 128'({bus.i_ready, bus.i_err, bus.i_rdata, bus.d_ready, bus.d_err, bus.d_rdata,
                   bus.m_valid, bus.m_we, bus.m_addr, bus.m_wdata});
   endfunction

   function automatic req_t mk(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                               input int a, input int r, input logic [31:0] rd);
      req_t q;
      q.addr = addr; q.we = we; q.wdata = wd; q.a = 16'(a); q.r = 16'(r); q.rd = rd;
      return q;
   endfunction

   function automatic req_t rand_req(input bit is_data);
      req_t        q;
      int          sel;
      logic [31:0] woff;
      woff = 32'($urandom_range(0, (1 << AW) - 1)) << 2;
      case ($urandom_range(0, 9))
         0:       q.addr = BASE + woff + 32'($urandom_range(1, 3));
         1:       q.addr = BASE - 32'(4 * $urandom_range(1, 64));
         2:       q.addr = BASE + 32'(WIN) + 32'(4 * $urandom_range(0, 64));
         3:       q.addr = ($urandom_range(0, 1) == 1) ? BASE : BASE + 32'(WIN) - 32'd4;
         default: q.addr = BASE + woff;
      endcase
      q.we    = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
      q.wdata = $urandom;
      sel = $urandom_range(0, 9);
      q.a = (sel < 6) ? 16'($urandom_range(0, 3)) : (sel == 6) ? 16'(TO - 1) :
            (sel == 7) ? 16'(TO) : (sel == 8) ? 16'(TO + 1) : 16'd0;
      sel = $urandom_range(0, 9);
      q.r = (sel < 6) ? 16'($urandom_range(1, 3)) : (sel == 6) ? 16'(TO) :
            (sel == 7) ? 16'(TO + 1) : (sel == 8) ? 16'(TO + 3) : 16'd1;
      q.rd = $urandom;
      return q;
   endfunction

   task automatic model_clear();
      busy = 0; last_d = 0; i_act = 0; d_act = 0; i_done = 0; d_done = 0;
      iq.delete(); dq.delete();
      rv_cyc = -1; acc_cyc = -1; cmd_end = -1; t_ready = -1;
      i_rd_m = '0; d_rd_m = '0; d_rd_known = 1;
   endtask

   // Model decision for a request sampled by an idle arbiter in cycle cyc.
   task automatic model_grant();
      logic [31:0]     off;
      longint unsigned offl;
      int              a, r;
      g_d   = d_act && (!i_act || !last_d);
      last_d = g_d;
      cur   = g_d ? d_cur : i_cur;
      g_we  = g_d && cur.we;
      g_cyc = cyc;
      g_wdata = bus.d_wdata;
      busy  = 1;
      off   = cur.addr - BASE;
      offl  = 64'(off);
      g_bad = (cur.addr[1:0] != 2'b00) || (offl >= WIN);
      g_maddr = AW'(off >> 2);
      a = int'(cur.a);
      r = int'(cur.r);
      acc_cyc = -1;
      if (g_bad) begin
         cmd_end = g_cyc; t_ready = g_cyc + 1; e_err = 1; e_rd = '0;
      end else if (a >= TO) begin
         cmd_end = g_cyc + TO; t_ready = g_cyc + TO + 1; e_err = 1; e_rd = '0;
      end else begin
         acc_cyc = g_cyc + 1 + a;
         cmd_end = acc_cyc;
         if (g_we) begin
            t_ready = acc_cyc + 1; e_err = 0; e_rd = '0;
         end else begin
            rv_cyc  = acc_cyc + r;
            rv_data = cur.rd;
            if (r <= TO) begin
               t_ready = rv_cyc + 1; e_err = 0; e_rd = cur.rd;
            end else begin
               t_ready = acc_cyc + 1 + TO; e_err = 1; e_rd = '0;
            end
         end
      end
   endtask

   // Cycle loop: requesters, memory responder and checks. abort_at>0 pulls reset mid-run.
   task automatic run(input int n_rand, input int abort_at, input int budget);
      int  ncyc = 0;
      int  rand_left = n_rand;
      bit  exp_ir, exp_dr, exp_mv;
      while (1) begin
         @(posedge clk);
         #1;
         cyc++;
         ncyc++;
         if (ncyc > budget) begin
            check_eq("run_budget", 128'(0), 128'(1));
            break;
         end
         if (abort_at != 0 && ncyc == abort_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_eq("reset_async_outs", all_outs(), 128'(0));
            model_clear();
            bus.i_req = 0; bus.d_req = 0; bus.m_ready = 0; bus.m_rvalid = 0;
            break;
         end

         if (i_done) begin i_act = 0; i_done = 0; end
         if (d_done) begin d_act = 0; d_done = 0; end
         if (!i_act && iq.size() == 0 && rand_left > 0 && $urandom_range(0, 2) == 0) begin
            iq.push_back(rand_req(0)); rand_left--;
         end
         if (!d_act && dq.size() == 0 && rand_left > 0 && $urandom_range(0, 2) == 0) begin
            dq.push_back(rand_req(1)); rand_left--;
         end
         if (!i_act && iq.size() > 0) begin i_cur = iq.pop_front(); i_act = 1; end
         if (!d_act && dq.size() > 0) begin d_cur = dq.pop_front(); d_act = 1; end

         if (!busy && !i_act && !d_act && rand_left == 0) begin
            bus.i_req = 0; bus.d_req = 0; bus.m_ready = 0; bus.m_rvalid = 0;
            break;
         end

         bus.i_req   = i_act;
         bus.i_addr  = i_act ? i_cur.addr : $urandom;
         bus.d_req   = d_act;
         bus.d_we    = d_act ? d_cur.we : 1'($urandom_range(0, 1));
         bus.d_addr  = d_act ? d_cur.addr : $urandom;
         bus.d_wdata = d_act ? d_cur.wdata : $urandom;

         if (!busy && (i_act || d_act)) model_grant();

         if (busy && !g_bad && cyc > g_cyc && cyc <= cmd_end)
            bus.m_ready = (cyc == acc_cyc);
         else
            bus.m_ready = 1'($urandom_range(0, 1));
         bus.m_rvalid = (cyc == rv_cyc) || (!busy && $urandom_range(0, 3) == 0);
         bus.m_rdata  = (cyc == rv_cyc) ? rv_data : $urandom;

         exp_ir = busy && !g_d && cyc == t_ready;
         exp_dr = busy &&  g_d && cyc == t_ready;
         exp_mv = busy && !g_bad && cyc > g_cyc && cyc <= cmd_end;
         check_eq("i_ready", 128'(bus.i_ready), 128'(exp_ir));
         check_eq("d_ready", 128'(bus.d_ready), 128'(exp_dr));
         check_eq("m_valid", 128'(bus.m_valid), 128'(exp_mv));
         if (exp_mv) begin
            check_eq("m_addr",  128'(bus.m_addr),  128'(g_maddr));
            check_eq("m_we",    128'(bus.m_we),    128'(g_we));
            check_eq("m_wdata", 128'(bus.m_wdata), 128'(g_wdata));
         end
         if (exp_ir) begin
            check_eq("i_err",   128'(bus.i_err),   128'(e_err));
            check_eq("i_rdata", 128'(bus.i_rdata), 128'(e_rd));
            i_rd_m = e_rd;
            if (d_rd_known) check_eq("d_rdata_hold", 128'(bus.d_rdata), 128'(d_rd_m));
            i_done = 1; busy = 0;
         end
         if (exp_dr) begin
            check_eq("d_err", 128'(bus.d_err), 128'(e_err));
            if (!(g_we && !e_err)) begin
               check_eq("d_rdata", 128'(bus.d_rdata), 128'(e_rd));
               d_rd_m = e_rd; d_rd_known = 1;
            end else begin
               d_rd_known = 0;
            end
            check_eq("i_rdata_hold", 128'(bus.i_rdata), 128'(i_rd_m));
            d_done = 1; busy = 0;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
      bus.d_wdata = '0; bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outs", all_outs(), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait fetch
      iq.push_back(mk(32'h8002_0000, 0, 0, 0, 1, 32'h27BD_FFE8));
      run(0, 0, 200);

      // Simultaneous fetch and load, each re-raised back-to-back
      iq.push_back(mk(32'h8002_0004, 0, 0, 0, 1, 32'h1111_0001));
      iq.push_back(mk(32'h8002_0004, 0, 0, 1, 2, 32'h1111_0002));
      dq.push_back(mk(32'h8010_0000, 0, 32'h5, 0, 1, 32'h2222_0001));
      dq.push_back(mk(32'h8010_0000, 0, 32'h6, 2, 1, 32'h2222_0002));
      run(0, 0, 300);

      // Store with four wait states
      dq.push_back(mk(32'h8011_FFFC, 1, 32'hCAFE_F00D, 4, 1, 32'h0));
      run(0, 0, 200);

      // Bad addresses, plus the last in-range word and a bad fetch
      dq.push_back(mk(32'h8002_0002, 0, 0, 0, 1, 32'hDEAD_0001));
      dq.push_back(mk(32'h7FFF_FFFC, 0, 0, 0, 1, 32'hDEAD_0002));
      dq.push_back(mk(32'h8040_0000, 1, 32'h77, 0, 1, 32'hDEAD_0003));
      dq.push_back(mk(32'h803F_FFFC, 0, 0, 0, 1, 32'h3333_4444));
      iq.push_back(mk(32'h8040_0000, 0, 0, 0, 1, 32'hDEAD_0004));
      run(0, 0, 300);

      // Read timeout with a late stray m_rvalid, then a store whose accept never comes
      iq.push_back(mk(32'h8000_1000, 0, 0, 0, TO + 2, 32'hBAD0_BAD0));
      dq.push_back(mk(32'h8000_2000, 1, 32'h99, TO, 1, 32'h0));
      run(0, 0, 400);

      // Randomised traffic
      run(300, 0, 40000);

      // Reset in the middle of a read, then a fresh fetch
      iq.push_back(mk(32'h8000_0040, 0, 0, 0, 1000, 32'hFFFF_FFFF));
      run(0, 4, 100);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      iq.push_back(mk(32'h8000_0044, 0, 0, 0, 1, 32'h0BAD_CAFE));
      run(0, 0, 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
